uart_rx_fifo: RTL and testbench

Serial receive front end for the user project: oversamples one dedicated input pin, deserialises 8N1 UART frames and buffers the received bytes in a small first-word-fall-through FIFO. It sits directly upstream of the project core, between `ui_in[0]` and the core's byte-command consumer. It also decouples pin-level timing from the core's read cadence.

---
 rtl/uart_rx_fifo.sv | 236 +++++++++++++++++++++++
 tb/tb_uart_rx_fifo.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx_fifo.sv
// uart_rx_fifo: oversampling 8N1 UART receiver feeding a first-word-fall-through
// byte FIFO. Optional even-parity reception is enabled by defining the macro
// UART_RX_PARITY_EN; without it the frame is plain 8N1 and parity_err is tied low.
module uart_rx_fifo #(
  parameter int unsigned CLKS_PER_BIT = 87,
  parameter int unsigned FIFO_DEPTH   = 4
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         ena,
  input  logic                         rx,
  input  logic                         rd_en,
  output logic [7:0]                   rd_data,
  output logic                         rd_valid,
  output logic [$clog2(FIFO_DEPTH):0]  count,
  output logic                         frame_err,
  output logic                         parity_err,
  output logic                         overflow
);

  localparam int unsigned CNT_W = $clog2(CLKS_PER_BIT + 1);
  localparam int unsigned AW    = $clog2(FIFO_DEPTH);
  localparam int unsigned PW    = AW + 1;

`ifdef UART_RX_PARITY_EN
  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } state_e;
`else
  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    START = 3'd1,
    DATA  = 3'd2,
    STOP  = 3'd4
  } state_e;
`endif

  state_e            state_q, state_d;
  logic              sync1_q, sync2_q, rxd_q;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [2:0]        bit_q, bit_d;
  logic [7:0]        shift_q, shift_d;
  logic              frame_err_q, frame_err_d;
  logic              push_c;
  logic              rx_s, fall_c, tc_c;

  logic [7:0]        mem_q [FIFO_DEPTH];
  logic [PW-1:0]     wptr_q, wptr_d, rptr_q, rptr_d;
  logic [PW-1:0]     count_q, count_d;
  logic              rd_valid_q, rd_valid_d;
  logic              overflow_q, overflow_d;
  logic              full_c, pop_c, wr_c;

`ifdef UART_RX_PARITY_EN
  logic              perr_q, perr_d;
  logic              parity_err_q, parity_err_d;
`endif

  assign rx_s   = sync2_q;
  assign fall_c = rxd_q & ~rx_s;
  assign tc_c   = (cnt_q == CNT_W'(1));

  // Receiver registers: synchroniser, edge history, FSM state and datapath
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q     <= 1'b1;
      sync2_q     <= 1'b1;
      rxd_q       <= 1'b1;
      state_q     <= IDLE;
      cnt_q       <= '0;
      bit_q       <= '0;
      shift_q     <= '0;
      frame_err_q <= 1'b0;
`ifdef UART_RX_PARITY_EN
      perr_q       <= 1'b0;
      parity_err_q <= 1'b0;
`endif
    end else begin
      sync1_q     <= rx;
      sync2_q     <= sync1_q;
      rxd_q       <= sync2_q;
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      bit_q       <= bit_d;
      shift_q     <= shift_d;
      frame_err_q <= frame_err_d;
`ifdef UART_RX_PARITY_EN
      perr_q       <= perr_d;
      parity_err_q <= parity_err_d;
`endif
    end
  end

  // Receiver next-state: bit timing, sampling, error detection and push request
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    bit_d       = bit_q;
    shift_d     = shift_q;
    frame_err_d = 1'b0;
    push_c      = 1'b0;
`ifdef UART_RX_PARITY_EN
    perr_d       = perr_q;
    parity_err_d = 1'b0;
`endif
    if (!ena) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE: begin
          if (fall_c) begin
            cnt_d   = CNT_W'(CLKS_PER_BIT / 2);
            state_d = START;
`ifdef UART_RX_PARITY_EN
            perr_d  = 1'b0;
`endif
          end
        end
        START: begin
          if (tc_c) begin
            if (!rx_s) begin
              state_d = DATA;
              bit_d   = 3'd0;
              cnt_d   = CNT_W'(CLKS_PER_BIT);
            end else begin
              state_d = IDLE;
            end
          end else begin
            cnt_d = cnt_q - CNT_W'(1);
          end
        end
        DATA: begin
          if (tc_c) begin
            shift_d = {rx_s, shift_q[7:1]};
            cnt_d   = CNT_W'(CLKS_PER_BIT);
            if (bit_q == 3'd7) begin
`ifdef UART_RX_PARITY_EN
              state_d = PARITY;
`else
              state_d = STOP;
`endif
            end else begin
              bit_d = bit_q + 3'd1;
            end
          end else begin
            cnt_d = cnt_q - CNT_W'(1);
          end
        end
`ifdef UART_RX_PARITY_EN
        PARITY: begin
          if (tc_c) begin
            if (rx_s != ^shift_q) begin
              parity_err_d = 1'b1;
              perr_d       = 1'b1;
            end
            cnt_d   = CNT_W'(CLKS_PER_BIT);
            state_d = STOP;
          end else begin
            cnt_d = cnt_q - CNT_W'(1);
          end
        end
`endif
        STOP: begin
          if (tc_c) begin
            state_d = IDLE;
            if (!rx_s) begin
              frame_err_d = 1'b1;
`ifdef UART_RX_PARITY_EN
            end else if (!perr_q) begin
`else
            end else begin
`endif
              push_c = 1'b1;
            end
          end else begin
            cnt_d = cnt_q - CNT_W'(1);
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  assign full_c = (wptr_q[AW] != rptr_q[AW]) && (wptr_q[AW-1:0] == rptr_q[AW-1:0]);

  // FIFO next-state: simultaneous pop frees the slot a push into a full FIFO needs
  always_comb begin
    pop_c      = rd_en && rd_valid_q;
    wr_c       = push_c && (!full_c || pop_c);
    overflow_d = push_c && full_c && !pop_c;
    wptr_d     = wr_c  ? (wptr_q + PW'(1)) : wptr_q;
    rptr_d     = pop_c ? (rptr_q + PW'(1)) : rptr_q;
    count_d    = wptr_d - rptr_d;
    rd_valid_d = (wptr_d != rptr_d);
  end

  // FIFO pointers and registered status
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr_q     <= '0;
      rptr_q     <= '0;
      count_q    <= '0;
      rd_valid_q <= 1'b0;
      overflow_q <= 1'b0;
    end else begin
      wptr_q     <= wptr_d;
      rptr_q     <= rptr_d;
      count_q    <= count_d;
      rd_valid_q <= rd_valid_d;
      overflow_q <= overflow_d;
    end
  end

  // FIFO storage, written with the byte completed at the stop sample
  always_ff @(posedge clk) begin
    if (wr_c) begin
      mem_q[wptr_q[AW-1:0]] <= shift_q;
    end
  end

  assign rd_data   = rd_valid_q ? mem_q[rptr_q[AW-1:0]] : 8'h00;
  assign rd_valid  = rd_valid_q;
  assign count     = count_q;
  assign frame_err = frame_err_q;
  assign overflow  = overflow_q;
`ifdef UART_RX_PARITY_EN
  assign parity_err = parity_err_q;
`else
  assign parity_err = 1'b0;
`endif

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Directed bench for uart_rx_fifo with CLKS_PER_BIT=4, FIFO_DEPTH=4.
module tb_uart_rx_fifo;

  localparam int unsigned CPB   = 4;
  localparam int unsigned DEPTH = 4;

  logic       clk = 1'b0;
  logic       rst_n, ena, rx, rd_en;
  logic [7:0] rd_data;
  logic       rd_valid;
  logic [2:0] count;
  logic       frame_err, parity_err, overflow;

  int checks = 0;
  int errors = 0;
  int n_fe = 0, n_pe = 0, n_ov = 0;
  int fe0, pe0, ov0;

  uart_rx_fifo #(.CLKS_PER_BIT(CPB), .FIFO_DEPTH(DEPTH)) dut (
    .clk(clk), .rst_n(rst_n), .ena(ena), .rx(rx), .rd_en(rd_en),
    .rd_data(rd_data), .rd_valid(rd_valid), .count(count),
    .frame_err(frame_err), .parity_err(parity_err), .overflow(overflow)
  );

  always #5 clk = ~clk;

  // Pulse tallies so whole windows can be checked for unexpected flags
  always @(posedge clk) begin
    if (frame_err)  n_fe <= n_fe + 1;
    if (parity_err) n_pe <= n_pe + 1;
    if (overflow)   n_ov <= n_ov + 1;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h exp %0h", tag, got, exp);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic drive_bit(input logic b);
    rx = b;
    idle(CPB);
  endtask

`ifdef UART_RX_PARITY_EN
  task automatic send_frame_p(input logic [7:0] d, input logic stop_b, input logic par_b);
    drive_bit(1'b0);
    for (int i = 0; i < 8; i++) drive_bit(d[i]);
    drive_bit(par_b);
    drive_bit(stop_b);
  endtask

  task automatic send_frame(input logic [7:0] d, input logic stop_b);
    send_frame_p(d, stop_b, ^d);
  endtask
`else
  task automatic send_frame(input logic [7:0] d, input logic stop_b);
    drive_bit(1'b0);
    for (int i = 0; i < 8; i++) drive_bit(d[i]);
    drive_bit(stop_b);
  endtask
`endif

  task automatic pop_chk(input logic [7:0] exp);
    chk("pop_valid", 32'(rd_valid), 32'd1);
    chk("pop_data", 32'(rd_data), 32'(exp));
    rd_en = 1'b1;
    @(posedge clk);
    #1;
    rd_en = 1'b0;
  endtask

  initial begin
    logic [7:0] half_byte;
    rst_n = 1'b0;
    ena   = 1'b1;
    rx    = 1'b1;
    rd_en = 1'b0;
    idle(2);
    chk("rst_count", 32'(count), 32'd0);
    chk("rst_valid", 32'(rd_valid), 32'd0);
    chk("rst_data", 32'(rd_data), 32'd0);
    chk("rst_flags", 32'({frame_err, parity_err, overflow}), 32'd0);
    rst_n = 1'b1;
    idle(2);

    // Reset in the middle of a frame wipes the FIFO and the partial frame
    send_frame(8'h11, 1'b1);
    idle(1);
    chk("pre_rst_count", 32'(count), 32'd1);
    half_byte = 8'h3C;
    drive_bit(1'b0);
    for (int i = 0; i < 4; i++) drive_bit(half_byte[i]);
    rst_n = 1'b0;
    rx    = 1'b1;
    #1;
    chk("midrst_count", 32'(count), 32'd0);
    chk("midrst_valid", 32'(rd_valid), 32'd0);
    chk("midrst_data", 32'(rd_data), 32'd0);
    chk("midrst_flags", 32'({frame_err, parity_err, overflow}), 32'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    idle(3);
    send_frame(8'hA5, 1'b1);
    idle(1);
    chk("post_rst_data", 32'(rd_data), 32'hA5);
    chk("post_rst_count", 32'(count), 32'd1);
    pop_chk(8'hA5);
    chk("post_rst_empty", 32'(rd_valid), 32'd0);

    // Back-to-back frames fill the FIFO and read back in order
    send_frame(8'h01, 1'b1);
    send_frame(8'h80, 1'b1);
    send_frame(8'hFF, 1'b1);
    send_frame(8'h55, 1'b1);
    idle(1);
    chk("fill_count", 32'(count), 32'd4);
    pop_chk(8'h01);
    pop_chk(8'h80);
    pop_chk(8'hFF);
    chk("fill_count_1", 32'(count), 32'd1);
    pop_chk(8'h55);
    chk("drain_valid", 32'(rd_valid), 32'd0);
    chk("drain_count", 32'(count), 32'd0);

    // Push into a full FIFO: dropped without a read, accepted with one
    send_frame(8'h11, 1'b1);
    send_frame(8'h22, 1'b1);
    send_frame(8'h33, 1'b1);
    send_frame(8'h44, 1'b1);
    idle(1);
    chk("full_count", 32'(count), 32'd4);
    ov0 = n_ov;
    send_frame(8'h77, 1'b1);
    @(posedge clk);
    #1;
    chk("ovf_pulse", 32'(overflow), 32'd1);
    @(posedge clk);
    #1;
    chk("ovf_clear", 32'(overflow), 32'd0);
    chk("ovf_count", 32'(count), 32'd4);
    chk("ovf_tally", 32'(n_ov - ov0), 32'd1);
    send_frame(8'h77, 1'b1);
    rd_en = 1'b1;
    @(posedge clk);
    #1;
    rd_en = 1'b0;
    chk("rdpush_ovf", 32'(overflow), 32'd0);
    chk("rdpush_count", 32'(count), 32'd4);
    idle(2);
    chk("rdpush_tally", 32'(n_ov - ov0), 32'd1);
    pop_chk(8'h22);
    pop_chk(8'h33);
    pop_chk(8'h44);
    pop_chk(8'h77);
    chk("ovf_drain", 32'(rd_valid), 32'd0);

    // Low stop bit raises frame_err and stores nothing
    fe0 = n_fe;
    send_frame(8'h5A, 1'b0);
    rx = 1'b1;
    @(posedge clk);
    #1;
    chk("ferr_pulse", 32'(frame_err), 32'd1);
    @(posedge clk);
    #1;
    chk("ferr_clear", 32'(frame_err), 32'd0);
    chk("ferr_count", 32'(count), 32'd0);
    chk("ferr_tally", 32'(n_fe - fe0), 32'd1);
    idle(4);

    // Single-cycle glitch on the idle line is rejected silently
    fe0 = n_fe; pe0 = n_pe; ov0 = n_ov;
    rx = 1'b0;
    idle(1);
    rx = 1'b1;
    idle(20);
    chk("glitch_flags", 32'((n_fe - fe0) + (n_pe - pe0) + (n_ov - ov0)), 32'd0);
    chk("glitch_count", 32'(count), 32'd0);
    chk("glitch_valid", 32'(rd_valid), 32'd0);

    // Dropping ena mid-frame discards the partial byte without flags
    fe0 = n_fe; pe0 = n_pe; ov0 = n_ov;
    half_byte = 8'hC3;
    drive_bit(1'b0);
    for (int i = 0; i < 3; i++) drive_bit(half_byte[i]);
    ena = 1'b0;
    rx  = 1'b1;
    idle(10);
    ena = 1'b1;
    idle(4);
    send_frame(8'h3C, 1'b1);
    idle(2);
    chk("ena_count", 32'(count), 32'd1);
    chk("ena_data", 32'(rd_data), 32'h3C);
    chk("ena_flags", 32'((n_fe - fe0) + (n_pe - pe0) + (n_ov - ov0)), 32'd0);
    pop_chk(8'h3C);

`ifdef UART_RX_PARITY_EN
    // Even parity: 0x07 carries parity bit 1
    pe0 = n_pe; fe0 = n_fe;
    send_frame_p(8'h07, 1'b1, 1'b1);
    idle(1);
    chk("par_ok_count", 32'(count), 32'd1);
    chk("par_ok_tally", 32'(n_pe - pe0), 32'd0);
    pop_chk(8'h07);
    send_frame_p(8'h07, 1'b1, 1'b0);
    idle(2);
    chk("par_bad_count", 32'(count), 32'd0);
    chk("par_bad_tally", 32'(n_pe - pe0), 32'd1);
    chk("par_bad_ferr", 32'(n_fe - fe0), 32'd0);
`else
    chk("no_parity_err", 32'(n_pe), 32'd0);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
